bcd_down_timer: RTL
===================

// Module: bcd_down_timer
// PURPOSE
//  Multi-digit BCD countdown timer, the down-counting companion of the BCD digit up-counter.
//  Loads a packed-BCD start value and decrements once per incoming tick strobe (1 Hz from the
//  game tick generator), with borrow rippling across digits. Flags expiry with a 1-cycle pulse
//  plus a level. Drives the game clock and power-up duration shown on the VGA score/timer digits.
// PARAMETERS
//  DIGITS       3        number of BCD digits; count width = 4*DIGITS
//  WARN_THRESH  12'h010  packed-BCD warning threshold (used only with TIMER_WARN_EN)
// PORTS
//  clk            in   1         system clock
//  resetN         in   1         reset, asynchronous, active-low
//  load           in   1         1-cycle strobe: load load_val, go IDLE
//  load_val       in   4*DIGITS  packed-BCD start value, digit 0 = bits[3:0]
//  start          in   1         1-cycle strobe: start/resume countdown
//  pause          in   1         1-cycle strobe: freeze countdown
//  tick           in   1         1-cycle decrement strobe
//  count          out  4*DIGITS  current packed-BCD value
//  running        out  1         high while state==RUN
//  expired        out  1         high while state==DONE
//  expired_pulse  out  1         exactly one cycle on entry to DONE
//  warn           out  1         low-time warning (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: count=0, state=IDLE, running=0, expired=0, expired_pulse=0, warn=0. All outputs registered.
//  - States IDLE, RUN, PAUSE, DONE. Priority each cycle: load > pause > start > tick.
//  - load, any state: count<=load_val, any nibble >9 saturated to 9; ->IDLE; expired cleared.
//  - IDLE: start & count!=0 -> RUN. start & count==0 -> ignored, stay IDLE.
//  - RUN: pause -> PAUSE (pause wins over start/tick in the same cycle).
//         tick -> count decremented by 1 on next edge (1-cycle latency).
//         Digit==0 with borrow-in -> 9, borrow-out; otherwise digit-1.
//         If the decrement result is 0: ->DONE; expired_pulse=1 in that same registered cycle.
//         count==0 in RUN (defensive): ->DONE on next edge, no decrement, no wrap to 9..9.
//  - PAUSE: start -> RUN (start & pause together: stay PAUSE). Ticks ignored, count frozen.
//  - DONE: count held at 0. Only load leaves DONE. Ticks, start, pause ignored.
//  - Ticks outside RUN are dropped, never queued.
//  - Reset mid-countdown: immediate return to reset values. No partial-decrement state survives.
// CONFIGURATION
//  - Macro TIMER_WARN_EN defined: warn = (state==RUN||state==PAUSE) && count < WARN_THRESH.
//    Compare numerically on packed BCD. warn is registered, updates with count.
//  - Macro TIMER_WARN_EN undefined: warn tied to 0. Port is kept so instantiations don't change.
// STRUCTURE
//  - Package timer_pkg: typedef enum timer_state_t {IDLE,RUN,PAUSE,DONE}; typedef logic [3:0] bcd_t;
//    constant BCD_MAX = 4'h9.
//  - Sub-module bcd_down_digit: one digit, inputs dec_en and borrow_in, outputs digit and borrow_out.
//    Handles load and saturation. Generate-instantiated DIGITS times in a borrow chain.
//  - Top holds the FSM, zero detect, the expiry pulse and the warn logic.
// TESTING
//  1. load 12'h005, start, 5 ticks -> count 004,003,002,001,000; expired_pulse=1 for 1 cycle after
//     the 5th tick; expired=1 and running=0 afterwards.
//  2. load 12'h100, start, 1 tick -> count 12'h099. Then 99 more ticks -> 000 and DONE.
//  3. load 12'h030, start, 2 ticks, pause, 4 ticks -> count stays 12'h028.
//     Then start, 1 tick -> 12'h027.
//  4. RUN with load and tick in the same cycle -> count=load_val, state IDLE.
//     load_val 12'h0C7 -> count 12'h097.
//  5. resetN low while RUN at 12'h042 -> all outputs 0, IDLE.
//     Then start with count 0 -> stays IDLE, running=0.
//  6. TIMER_WARN_EN, WARN_THRESH 12'h010: count 12'h011 -> warn=0; tick -> 12'h010, warn=0;
//     tick -> 12'h009, warn=1; DONE -> warn=0. Without the macro, warn=0 throughout.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'h9;

  // Clamp a nibble into the legal BCD range so a bad load never escapes.
  function automatic bcd_t satBcd(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One registered BCD digit of the countdown chain: loads with saturation and
// decrements when enabled and a borrow arrives from the digit below.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec_en,
  input  logic borrow_in,
  output bcd_t digit,
  output logic borrow_out
);

  bcd_t r_digit;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_digit <= '0;
    end else if (load) begin
      r_digit <= satBcd(load_val);
    end else if (dec_en && borrow_in) begin
      r_digit <= (r_digit == 4'h0) ? BCD_MAX : r_digit - 4'h1;
    end
  end

  assign digit      = r_digit;
  assign borrow_out = borrow_in && (r_digit == 4'h0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with run/pause/expire control.
// Optional low-time warning output is enabled by defining TIMER_WARN_EN.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int                    DIGITS      = 3,
  parameter logic [4*DIGITS-1:0]   WARN_THRESH = 12'h010
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  expired,
  output logic                  expired_pulse,
  output logic                  warn
);

  localparam int W = 4 * DIGITS;

  timer_state_t r_state, w_nextState;
  logic [W-1:0] w_count;
  logic         w_dec;
  logic         w_countZero;
  logic         w_countOne;
  logic         r_running;
  logic         r_expired;
  logic         r_expiredPulse;
  logic         w_unused;

  // Borrow chain: each digit borrows from the one below; digit 0 always sees the decrement.
  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic w_bin;
    logic w_bout;
    if (gi == 0) begin : g_first
      assign w_bin = 1'b1;
    end else begin : g_chain
      assign w_bin = g_digit[gi-1].w_bout;
    end
    bcd_down_digit u_digit (
      .clk        (clk),
      .resetN     (resetN),
      .load       (load),
      .load_val   (load_val[4*gi +: 4]),
      .dec_en     (w_dec),
      .borrow_in  (w_bin),
      .digit      (w_count[4*gi +: 4]),
      .borrow_out (w_bout)
    );
  end

  assign w_countZero = (w_count == '0);
  assign w_countOne  = (w_count == W'(1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // A decrement from 1 lands on 0, so expiry is decided in the same cycle as the final tick.
  always_comb begin
    w_nextState = r_state;
    w_dec       = 1'b0;
    case (r_state)
      IDLE:  if (start && !pause && !w_countZero) w_nextState = RUN;
      RUN: begin
        if (pause) begin
          w_nextState = PAUSE;
        end else if (w_countZero) begin
          w_nextState = DONE;
        end else if (tick) begin
          w_dec = 1'b1;
          if (w_countOne) w_nextState = DONE;
        end
      end
      PAUSE: if (start && !pause) w_nextState = RUN;
      DONE:  w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
    if (load) begin
      w_nextState = IDLE;
      w_dec       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_running      <= 1'b0;
      r_expired      <= 1'b0;
      r_expiredPulse <= 1'b0;
    end else begin
      r_running      <= (w_nextState == RUN);
      r_expired      <= (w_nextState == DONE);
      r_expiredPulse <= (w_nextState == DONE) && (r_state != DONE);
    end
  end

  assign count         = w_count;
  assign running       = r_running;
  assign expired       = r_expired;
  assign expired_pulse = r_expiredPulse;

`ifdef TIMER_WARN_EN
  logic r_warn;

  // Look at the count the digits are about to hold: after a decrement, new < T exactly when old <= T.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= ((w_nextState == RUN) || (w_nextState == PAUSE)) &&
                (w_dec ? (w_count <= WARN_THRESH) : (w_count < WARN_THRESH));
    end
  end

  assign warn     = r_warn;
  assign w_unused = g_digit[DIGITS-1].w_bout;
`else
  assign warn     = 1'b0;
  assign w_unused = ^{WARN_THRESH, g_digit[DIGITS-1].w_bout};
`endif

endmodule
